// File: rtl/uart_in_arbiter.sv
// rtl/uart_in_arbiter.sv - round-robin merge of UART receive bytes into one shared FIFO
// Each byte leaves as a two-byte frame {0xA, channel} then data, so the drain side can demux.
module uart_in_arbiter #(
    parameter int UART_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [UART_COUNT-1:0]   rx_valid,
    input  logic [8*UART_COUNT-1:0] rx_data,
    input  logic                    fifo_full,
    output logic                    fifo_write,
    output logic [7:0]              fifo_write_data,
    output logic [UART_COUNT-1:0]   overrun,
    input  logic [UART_COUNT-1:0]   overrun_clr
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                state;
    state_t                state_next;
    logic [UART_COUNT-1:0] pend;
    logic [UART_COUNT-1:0] pend_clr;
    logic [7:0]            hold [UART_COUNT];
    logic [3:0]            g;
    logic [3:0]            last;
    logic [3:0]            grant;
    logic [3:0]            grant_hi;
    logic [3:0]            grant_lo;
    logic                  found_hi;

    // Lowest pending channel above last wins; otherwise wrap to the lowest pending overall.
    always_comb begin
        grant_hi = 4'd0;
        grant_lo = 4'd0;
        found_hi = 1'b0;
        for (int i = UART_COUNT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_lo = 4'(i);
                if (4'(i) > last) begin
                    grant_hi = 4'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pend) state_next = HEADER;
            HEADER:  if (!fifo_full) state_next = DATA;
            DATA:    if (!fifo_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_write      = (state == HEADER || state == DATA) && !fifo_full;
        fifo_write_data = 8'h00;
        pend_clr        = '0;
        if (state == HEADER) begin
            fifo_write_data = {4'hA, g};
        end
        for (int i = 0; i < UART_COUNT; i++) begin
            if (state == DATA && g == 4'(i)) begin
                fifo_write_data = hold[i];
                pend_clr[i]     = !fifo_full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            g       <= 4'd0;
            last    <= 4'(UART_COUNT - 1);
            pend    <= '0;
            overrun <= '0;
            for (int i = 0; i < UART_COUNT; i++) begin
                hold[i] <= 8'h00;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && |pend) begin
                g    <= grant;
                last <= grant;
            end
            for (int i = 0; i < UART_COUNT; i++) begin
                // A byte arriving on the cycle its predecessor is drained refills the slot.
                if (rx_valid[i] && (!pend[i] || pend_clr[i])) begin
                    hold[i] <= rx_data[8*i +: 8];
                    pend[i] <= 1'b1;
                end else if (pend_clr[i]) begin
                    pend[i] <= 1'b0;
                end
                if (overrun_clr[i]) begin
                    overrun[i] <= 1'b0;
                end else if (rx_valid[i] && pend[i] && !pend_clr[i]) begin
                    overrun[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_in_arbiter.sv
// tb/tb_uart_in_arbiter.sv - self-checking bench for uart_in_arbiter
module tb_uart_in_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rx_valid = '0;
    logic [31:0] rx_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [7:0]  fifo_write_data;
    logic [3:0]  overrun;
    logic [3:0]  overrun_clr = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    uart_in_arbiter #(.UART_COUNT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_write_data (fifo_write_data),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        cyc();
    endtask

    // Scoreboard: every FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (reset && fifo_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, fifo_write_data}, 32'hFFFF_FFFF);
            end else begin
                check("fifo_byte", {24'h0, fifo_write_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vecs[0] = '{4'b1111, 32'h13121110, 8, 64'h13A3_12A2_11A1_10A0};
        vecs[1] = '{4'b1010, 32'h23002100, 4, 64'h0000_0000_23A3_21A1};
        vecs[2] = '{4'b1001, 32'h33000030, 4, 64'h0000_0000_33A3_30A0};
        vecs[3] = '{4'b0110, 32'h00424100, 4, 64'h0000_0000_42A2_41A1};
        vecs[4] = '{4'b1011, 32'h53005150, 6, 64'h0000_51A1_50A0_53A3};
        vecs[5] = '{4'b0101, 32'h00620060, 4, 64'h0000_0000_60A0_62A2};
        vecs[6] = '{4'b0001, 32'h00000070, 2, 64'h0000_0000_0000_70A0};

        // Reset with random strobes
        for (int k = 0; k < 2; k++) begin
            cyc();
            rx_valid = 4'($urandom);
            rx_data  = $urandom;
            @(negedge clk);
            check("rst_write", {31'h0, fifo_write}, 0);
            check("rst_data", {24'h0, fifo_write_data}, 0);
            check("rst_overrun", {28'h0, overrun}, 0);
        end
        cyc();
        reset    = 1'b1;
        rx_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", {31'h0, fifo_write}, 0);
            cyc();
        end

        // Table-driven frames, round-robin order derived by hand per record
        for (int v = 0; v < 7; v++) begin
            rx_valid = vecs[v].valid;
            rx_data  = vecs[v].data;
            for (int b = 0; b < vecs[v].n; b++) push(vecs[v].exp[8*b +: 8]);
            cyc();
            rx_valid = '0;
            wait_drain();
        end

        // Single byte with exact latency
        rx_valid = 4'b0100;
        rx_data  = 32'h00880000;
        push(8'hA2); push(8'h88);
        cyc();
        rx_valid = '0;
        cyc();
        @(negedge clk);
        check("single_hdr_wr", {31'h0, fifo_write}, 1);
        check("single_hdr", {24'h0, fifo_write_data}, 32'hA2);
        cyc();
        @(negedge clk);
        check("single_dat_wr", {31'h0, fifo_write}, 1);
        check("single_dat", {24'h0, fifo_write_data}, 32'h88);
        cyc();
        @(negedge clk);
        check("single_idle", {31'h0, fifo_write}, 0);
        cyc();

        // Back-pressure: five full cycles during HEADER
        rx_valid = 4'b0010;
        rx_data  = 32'h00009900;
        push(8'hA1); push(8'h99);
        cyc();
        rx_valid = '0;
        cyc();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            check("bp_stall", {31'h0, fifo_write}, 0);
            check("bp_hold_hdr", {24'h0, fifo_write_data}, 32'hA1);
        end
        cyc();
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_hdr_wr", {31'h0, fifo_write}, 1);
        cyc();
        @(negedge clk);
        check("bp_dat", {24'h0, fifo_write_data}, 32'h99);
        cyc();
        @(negedge clk);
        check("bp_idle", {31'h0, fifo_write}, 0);
        cyc();

        // Overrun while the FIFO is full
        fifo_full = 1'b1;
        rx_valid  = 4'b0010;
        rx_data   = 32'h00005500;
        push(8'hA1); push(8'h55);
        cyc();
        rx_data = 32'h00006600;
        cyc();
        rx_valid = '0;
        @(negedge clk);
        check("ovr_set", {28'h0, overrun}, 32'h2);
        repeat (3) cyc();
        fifo_full = 1'b0;
        wait_drain();
        repeat (2) cyc();
        check("ovr_sticky", {28'h0, overrun}, 32'h2);
        overrun_clr = 4'b0010;
        cyc();
        overrun_clr = '0;
        @(negedge clk);
        check("ovr_clr", {28'h0, overrun}, 0);
        cyc();

        // Recapture in the DATA write cycle
        rx_valid = 4'b0001;
        rx_data  = 32'h0000005A;
        push(8'hA0); push(8'h5A); push(8'hA0); push(8'h77);
        cyc();
        rx_valid = '0;
        cyc();
        cyc();
        rx_valid = 4'b0001;
        rx_data  = 32'h00000077;
        @(negedge clk);
        check("recap_in_data", {31'h0, fifo_write}, 1);
        cyc();
        rx_valid = '0;
        @(negedge clk);
        check("recap_no_ovr", {28'h0, overrun}, 0);
        wait_drain();
        check("recap_no_ovr_end", {28'h0, overrun}, 0);

        // Clear wins over a same-cycle overrun set
        fifo_full = 1'b1;
        rx_valid  = 4'b1000;
        rx_data   = 32'hC3000000;
        push(8'hA3); push(8'hC3);
        cyc();
        rx_data     = 32'hD3000000;
        overrun_clr = 4'b1000;
        cyc();
        rx_valid    = '0;
        overrun_clr = '0;
        @(negedge clk);
        check("clr_wins", {28'h0, overrun}, 0);
        cyc();
        fifo_full = 1'b0;
        wait_drain();

        repeat (4) cyc();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
